shape_pixel_writer: RTL and testbench

Consumer end of the shape-generator pixel stream. Issues the generator's start strobe, samples each generated (x, y) position, converts it to a linear frame-buffer address, and writes the pen colour to SDRAM through an Avalon-MM write master. Pulses the generator's acknowledge (`renew_start`) once each position is committed, then retires the frame. Sits between the rectangle/shape generators and the SDRAM controller.

---
 rtl/draw_pkg.sv | 23 ++
 rtl/fb_addr_calc.sv | 35 +++
 rtl/shape_pixel_writer.sv | 183 ++++++++++++++++++
 tb/tb_shape_pixel_writer.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/draw_pkg.sv
// Shared definitions for the shape drawing pipeline.
// - draw_state_t : state encoding of the pixel writer FSM
// - DefaultHRes / DefaultVRes : default visible frame size
// - SentinelX / SentinelY : idle position the generators park on (always off-screen)
package draw_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StSettle,
        StCheck,
        StAddr,
        StWrite,
        StAck,
        StFinish
    } draw_state_t;

    localparam int unsigned DefaultHRes = 800;
    localparam int unsigned DefaultVRes = 600;
    localparam int unsigned SentinelX   = 801;
    localparam int unsigned SentinelY   = 601;

endpackage

// File: rtl/fb_addr_calc.sv
// Registered frame-buffer address: addr = BASE_ADDR + y*H_RES + x, computed at full
// precision and truncated to ADDR_W. The register only loads while en is high, so the
// result stays stable for as long as a downstream write is stalled.
// Ports:
//   clk, rst  : clock, synchronous active-low reset (addr clears to 0)
//   en        : load a new address this cycle
//   x, y      : pixel position
//   addr      : registered word address
module fb_addr_calc
    import draw_pkg::*;
#(
    parameter int unsigned H_RES     = DefaultHRes,
    parameter int unsigned ADDR_W    = 23,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [15:0]       x,
    input  logic [15:0]       y,
    output logic [ADDR_W-1:0] addr
);

    // Wide enough for any 16-bit y times a 32-bit width plus offsets.
    localparam int unsigned FullW = 50;

    always_ff @(posedge clk) begin
        if (!rst) begin
            addr <= '0;
        end else if (en) begin
            addr <= ADDR_W'(FullW'(BASE_ADDR) + FullW'(y) * FullW'(H_RES) + FullW'(x));
        end
    end

endmodule

// File: rtl/shape_pixel_writer.sv
// Consumer end of the shape-generator pixel stream. Starts the generator, samples each
// generated position, writes the pen colour for on-screen positions to SDRAM through an
// Avalon-MM write master, acknowledges each position and retires the frame once the
// generator reports done and stops moving. A generator that stops moving without
// reporting done is aborted after STALL_MAX checks.
// Ports:
//   clk, rst                   : clock, synchronous active-low reset
//   draw_req, pen_color        : draw request (accepted only when idle) and its colour
//   gen_x, gen_y, gen_done     : generator position and all-done level
//   gen_start, gen_ack         : generator start / position-stored strobes
//   gen_new_frame              : tells the generator to park on its idle sentinel
//   avm_address, avm_write,
//   avm_writedata,
//   avm_waitrequest            : Avalon-MM write master
//   busy                       : high whenever not idle
//   frame_done, stall_err      : completion / stall-abort pulses
//   pix_count                  : pixels written in the current or last frame
// All outputs are registered.
module shape_pixel_writer
    import draw_pkg::*;
#(
    parameter int unsigned H_RES     = DefaultHRes,
    parameter int unsigned V_RES     = DefaultVRes,
    parameter int unsigned ADDR_W    = 23,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned STALL_MAX = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              draw_req,
    input  logic [DATA_W-1:0] pen_color,
    input  logic [15:0]       gen_x,
    input  logic [15:0]       gen_y,
    input  logic              gen_done,
    output logic              gen_start,
    output logic              gen_ack,
    output logic              gen_new_frame,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_write,
    output logic [DATA_W-1:0] avm_writedata,
    input  logic              avm_waitrequest,
    output logic              busy,
    output logic              frame_done,
    output logic              stall_err,
    output logic [19:0]       pix_count
);

    localparam int unsigned StallW = (STALL_MAX > 1) ? $clog2(STALL_MAX + 1) : 1;

    draw_state_t       state_q;
    logic [15:0]       cur_x_q;
    logic [15:0]       cur_y_q;
    logic [15:0]       last_x_q;
    logic [15:0]       last_y_q;
    logic              last_valid_q;
    logic [StallW-1:0] stall_cnt_q;

    logic new_pos;
    logic off_screen;
    logic addr_en;

    // Any change from the last committed position (or none committed yet) is new work,
    // even with gen_done already high, so the final pixel is never dropped.
    assign new_pos    = !last_valid_q || (gen_x != last_x_q) || (gen_y != last_y_q);
    assign off_screen = (32'(cur_x_q) >= H_RES) || (32'(cur_y_q) >= V_RES);
    assign addr_en    = (state_q == StAddr);

    // The address register doubles as avm_address: it loads only in ADDR, so it is
    // stable for the whole WRITE state including waitrequest stalls.
    fb_addr_calc #(
        .H_RES    (H_RES),
        .ADDR_W   (ADDR_W),
        .BASE_ADDR(BASE_ADDR)
    ) u_fb_addr_calc (
        .clk (clk),
        .rst (rst),
        .en  (addr_en),
        .x   (cur_x_q),
        .y   (cur_y_q),
        .addr(avm_address)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= StIdle;
            cur_x_q       <= '0;
            cur_y_q       <= '0;
            last_x_q      <= '0;
            last_y_q      <= '0;
            last_valid_q  <= 1'b0;
            stall_cnt_q   <= '0;
            gen_start     <= 1'b0;
            gen_ack       <= 1'b0;
            gen_new_frame <= 1'b0;
            avm_write     <= 1'b0;
            avm_writedata <= '0;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
            stall_err     <= 1'b0;
            pix_count     <= '0;
        end else begin
            // Strobes default low; each is raised for exactly the state it belongs to.
            gen_start     <= 1'b0;
            gen_ack       <= 1'b0;
            gen_new_frame <= 1'b0;
            frame_done    <= 1'b0;
            stall_err     <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (draw_req) begin
                        avm_writedata <= pen_color;
                        pix_count     <= '0;
                        last_valid_q  <= 1'b0;
                        stall_cnt_q   <= '0;
                        gen_start     <= 1'b1;
                        busy          <= 1'b1;
                        state_q       <= StStart;
                    end
                end
                StStart: begin
                    state_q <= StSettle;
                end
                StSettle: begin
                    state_q <= StCheck;
                end
                StCheck: begin
                    cur_x_q <= gen_x;
                    cur_y_q <= gen_y;
                    if (new_pos) begin
                        stall_cnt_q <= '0;
                        state_q     <= StAddr;
                    end else if (gen_done) begin
                        frame_done    <= 1'b1;
                        gen_new_frame <= 1'b1;
                        state_q       <= StFinish;
                    end else if (32'(stall_cnt_q) + 32'd1 >= STALL_MAX) begin
                        stall_err <= 1'b1;
                        busy      <= 1'b0;
                        state_q   <= StIdle;
                    end else begin
                        stall_cnt_q <= stall_cnt_q + 1'b1;
                    end
                end
                StAddr: begin
                    if (off_screen) begin
                        gen_ack <= 1'b1;
                        state_q <= StAck;
                    end else begin
                        avm_write <= 1'b1;
                        state_q   <= StWrite;
                    end
                end
                StWrite: begin
                    if (!avm_waitrequest) begin
                        avm_write <= 1'b0;
                        if (pix_count != '1) begin
                            pix_count <= pix_count + 20'd1;
                        end
                        gen_ack <= 1'b1;
                        state_q <= StAck;
                    end
                end
                StAck: begin
                    last_x_q     <= cur_x_q;
                    last_y_q     <= cur_y_q;
                    last_valid_q <= 1'b1;
                    state_q      <= StSettle;
                end
                StFinish: begin
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shape_pixel_writer.sv
module tb_shape_pixel_writer;

    localparam int HRes = 800;
    localparam int VRes = 600;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        draw_req = 1'b0;
    logic [15:0] pen_color = '0;
    logic [15:0] gen_x = 16'd801;
    logic [15:0] gen_y = 16'd601;
    logic        gen_done = 1'b0;
    logic        gen_start, gen_ack, gen_new_frame;
    logic [22:0] avm_address;
    logic        avm_write;
    logic [15:0] avm_writedata;
    logic        avm_waitrequest = 1'b0;
    logic        busy, frame_done, stall_err;
    logic [19:0] pix_count;

    shape_pixel_writer #(
        .STALL_MAX(15)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .draw_req       (draw_req),
        .pen_color      (pen_color),
        .gen_x          (gen_x),
        .gen_y          (gen_y),
        .gen_done       (gen_done),
        .gen_start      (gen_start),
        .gen_ack        (gen_ack),
        .gen_new_frame  (gen_new_frame),
        .avm_address    (avm_address),
        .avm_write      (avm_write),
        .avm_writedata  (avm_writedata),
        .avm_waitrequest(avm_waitrequest),
        .busy           (busy),
        .frame_done     (frame_done),
        .stall_err      (stall_err),
        .pix_count      (pix_count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint got, input longint want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    // ---------------- behavioural generator ----------------
    // mode 0: gen_done rises after the last position is acked
    // mode 1: gen_done rises together with the last position
    // mode 2: never done (frozen on the last position)
    logic [15:0] gpx[16];
    logic [15:0] gpy[16];
    int gn = 1, gmode = 0, gidx = 0;

    always @(posedge clk) begin
        if (gen_start) begin
            gidx     <= 0;
            gen_x    <= gpx[0];
            gen_y    <= gpy[0];
            gen_done <= (gmode == 1 && gn == 1);
        end else if (gen_ack) begin
            if (gidx + 1 < gn) begin
                gidx     <= gidx + 1;
                gen_x    <= gpx[gidx+1];
                gen_y    <= gpy[gidx+1];
                gen_done <= (gmode == 1 && gidx + 2 == gn);
            end else begin
                gen_done <= (gmode != 2);
            end
        end else if (gen_new_frame) begin
            gen_x    <= 16'd801;
            gen_y    <= 16'd601;
            gen_done <= 1'b0;
        end
    end

    // ---------------- Avalon slave + event monitor ----------------
    int wait_tab[16];
    int widx = 0, wcyc = 0;
    bit prev_stall = 0;
    logic [22:0] prev_addr;
    logic [15:0] prev_data;
    int wr_addr[$];
    int wr_data[$];
    int ack_cyc[$];
    int wr_cyc = 0, fd_cyc = 0, se_cyc = 0;
    int fd_cnt = 0, se_cnt = 0, gs_cnt = 0;

    always @(negedge clk) begin
        if (!rst) begin
            avm_waitrequest = 1'b0;
            wcyc = 0;
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                tests++;
                if (!avm_write || avm_address !== prev_addr || avm_writedata !== prev_data) begin
                    fails++;
                    $display("FAIL stall_hold: got write=%0b addr=%0d data=%h, expected 1/%0d/%h",
                             avm_write, avm_address, avm_writedata, prev_addr, prev_data);
                end
            end
            if (avm_write) begin
                if (wcyc < ((widx < 16) ? wait_tab[widx] : 0)) begin
                    avm_waitrequest = 1'b1;
                    wcyc++;
                end else begin
                    avm_waitrequest = 1'b0;
                    wr_addr.push_back(int'(avm_address));
                    wr_data.push_back(int'(avm_writedata));
                    wr_cyc = cyc;
                    widx++;
                    wcyc = 0;
                end
            end else begin
                avm_waitrequest = 1'b0;
            end
            prev_stall = avm_write && avm_waitrequest;
            prev_addr  = avm_address;
            prev_data  = avm_writedata;
            if (gen_ack) ack_cyc.push_back(cyc);
            if (gen_start) gs_cnt++;
            if (frame_done) begin fd_cnt++; fd_cyc = cyc; end
            if (stall_err) begin se_cnt++; se_cyc = cyc; end
            if (frame_done || gen_new_frame) check("done_with_new_frame", gen_new_frame, frame_done);
        end
    end

    // ---------------- reference expectations ----------------
    int exp_addr[$];
    int exp_lat[$];
    int exp_pix;
    int start_cyc;

    task automatic clear_logs();
        wr_addr.delete(); wr_data.delete(); ack_cyc.delete();
        exp_addr.delete(); exp_lat.delete();
        exp_pix = 0; widx = 0; wcyc = 0;
        fd_cnt = 0; se_cnt = 0; gs_cnt = 0;
        for (int i = 0; i < 16; i++) wait_tab[i] = 0;
    endtask

    // Reference model: a position is written iff on-screen; address is linear y*HRes + x.
    // Latency from the previous ack: 5 cycles on-screen (plus wait states), 4 off-screen,
    // one extra for the first position (START before the first SETTLE).
    task automatic add_pos(input int i, input int x, input int y, input int w);
        bit on;
        gpx[i] = 16'(x);
        gpy[i] = 16'(y);
        on = (x < HRes) && (y < VRes);
        if (on) begin
            wait_tab[exp_addr.size()] = w;
            exp_addr.push_back(y * HRes + x);
            exp_pix++;
        end
        exp_lat.push_back((i == 0 ? 1 : 0) + (on ? 5 + w : 4));
    endtask

    task automatic run_frame(input logic [15:0] color, input int extra_req);
        int k;
        @(negedge clk);
        draw_req  = 1'b1;
        pen_color = color;
        start_cyc = cyc;
        @(negedge clk);
        draw_req  = 1'b0;
        pen_color = 16'($urandom);
        check("start gen_start", gen_start, 1);
        check("start busy", busy, 1);
        check("start pix_count", pix_count, 0);
        for (k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (extra_req > 0 && cyc == start_cyc + extra_req) begin
                draw_req  = 1'b1;
                pen_color = ~color;
            end else begin
                draw_req = 1'b0;
            end
            if (frame_done || stall_err) break;
        end
        draw_req = 1'b0;
        check("frame terminated in time", k < 3000, 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic verify(input string tag, input logic [15:0] color, input int exp_fd,
                          input int exp_se);
        check({tag, " nwrites"}, wr_addr.size(), exp_addr.size());
        for (int i = 0; i < wr_addr.size() && i < exp_addr.size(); i++) begin
            check($sformatf("%s addr[%0d]", tag, i), wr_addr[i], exp_addr[i]);
            check($sformatf("%s data[%0d]", tag, i), wr_data[i], int'(color));
        end
        check({tag, " nacks"}, ack_cyc.size(), exp_lat.size());
        for (int i = 0; i < ack_cyc.size() && i < exp_lat.size(); i++) begin
            check($sformatf("%s lat[%0d]", tag, i),
                  ack_cyc[i] - ((i == 0) ? start_cyc : ack_cyc[i-1]), exp_lat[i]);
        end
        check({tag, " pix_count"}, pix_count, exp_pix);
        check({tag, " frame_done"}, fd_cnt, exp_fd);
        check({tag, " stall_err"}, se_cnt, exp_se);
        check({tag, " gen_start pulses"}, gs_cnt, 1);
        check({tag, " idle busy"}, busy, 0);
        if (exp_fd == 1 && wr_addr.size() > 0)
            check({tag, " write before frame_done"}, wr_cyc < fd_cyc, 1);
    endtask

    // ---------------- directed table ----------------
    typedef struct packed {
        logic [15:0]       color;
        logic [2:0]        n;
        logic [1:0]        mode;
        logic [3:0][15:0]  x;
        logic [3:0][15:0]  y;
        logic [3:0][3:0]   wt;
        logic [2:0]        exp_w;
        logic [3:0][22:0]  exp_a;
        logic [2:0]        exp_p;
        logic [3:0][3:0]   exp_l;
    } vec_t;

    vec_t vecs[6];

    task automatic load_vec(input vec_t v);
        int k;
        clear_logs();
        gn = int'(v.n);
        gmode = int'(v.mode);
        k = 0;
        for (int i = 0; i < gn; i++) begin
            gpx[i] = v.x[i];
            gpy[i] = v.y[i];
            if (v.x[i] < 16'(HRes) && v.y[i] < 16'(VRes)) begin
                wait_tab[k] = int'(v.wt[i]);
                k++;
            end
            exp_lat.push_back(int'(v.exp_l[i]));
        end
        for (int i = 0; i < int'(v.exp_w); i++) exp_addr.push_back(int'(v.exp_a[i]));
        exp_pix = int'(v.exp_p);
    endtask

    initial begin
        vecs[0] = '{16'hA5C3, 3'd3, 2'd0, {16'd0, 16'd12, 16'd11, 16'd10},
                    {16'd0, 16'd10, 16'd10, 16'd10}, 16'h0000, 3'd3,
                    {23'd0, 23'd8012, 23'd8011, 23'd8010}, 3'd3, {4'd0, 4'd5, 4'd5, 4'd6}};
        vecs[1] = '{16'h1234, 3'd3, 2'd0, {16'd0, 16'd12, 16'd11, 16'd10},
                    {16'd0, 16'd10, 16'd10, 16'd10}, 16'h0040, 3'd3,
                    {23'd0, 23'd8012, 23'd8011, 23'd8010}, 3'd3, {4'd0, 4'd5, 4'd9, 4'd6}};
        vecs[2] = '{16'hBEEF, 3'd2, 2'd1, {16'd0, 16'd0, 16'd0, 16'd801},
                    {16'd0, 16'd0, 16'd0, 16'd601}, 16'h0000, 3'd1,
                    {23'd0, 23'd0, 23'd0, 23'd0}, 3'd1, {4'd0, 4'd0, 4'd5, 4'd5}};
        vecs[3] = '{16'h0F0F, 3'd1, 2'd1, {16'd0, 16'd0, 16'd0, 16'd799},
                    {16'd0, 16'd0, 16'd0, 16'd599}, 16'h0000, 3'd1,
                    {23'd0, 23'd0, 23'd0, 23'd479999}, 3'd1, {4'd0, 4'd0, 4'd0, 4'd6}};
        vecs[4] = '{16'h7E57, 3'd4, 2'd0, {16'd0, 16'd800, 16'd799, 16'd0},
                    {16'd600, 16'd0, 16'd0, 16'd599}, 16'h0000, 3'd2,
                    {23'd0, 23'd0, 23'd799, 23'd479200}, 3'd2, {4'd4, 4'd4, 4'd5, 4'd6}};
        vecs[5] = '{16'hFFFF, 3'd1, 2'd0, {16'd0, 16'd0, 16'd0, 16'd3},
                    {16'd0, 16'd0, 16'd0, 16'd2}, 16'h0002, 3'd1,
                    {23'd0, 23'd0, 23'd0, 23'd1603}, 3'd1, {4'd0, 4'd0, 4'd0, 4'd8}};

        // Reset values
        clear_logs();
        repeat (3) @(negedge clk);
        check("rst gen_start", gen_start, 0);
        check("rst gen_ack", gen_ack, 0);
        check("rst gen_new_frame", gen_new_frame, 0);
        check("rst avm_write", avm_write, 0);
        check("rst busy", busy, 0);
        check("rst frame_done", frame_done, 0);
        check("rst stall_err", stall_err, 0);
        check("rst avm_address", avm_address, 0);
        check("rst avm_writedata", avm_writedata, 0);
        check("rst pix_count", pix_count, 0);
        rst = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            load_vec(vecs[v]);
            run_frame(vecs[v].color, 0);
            verify($sformatf("vec%0d", v), vecs[v].color, 1, 0);
        end

        // draw_req while busy is dropped
        load_vec(vecs[0]);
        run_frame(16'h5A5A, 4);
        verify("busy_drop", 16'h5A5A, 1, 0);

        // Frozen generator: one write then stall abort after 15 same-position checks
        clear_logs();
        gn = 1;
        gmode = 2;
        add_pos(0, 5, 5, 0);
        run_frame(16'h00C0, 0);
        verify("stall", 16'h00C0, 0, 1);
        if (ack_cyc.size() > 0) check("stall_err timing", se_cyc - ack_cyc[0], 17);

        // Reset while a write is stalled
        load_vec(vecs[0]);
        wait_tab[0] = 10;
        @(negedge clk);
        draw_req  = 1'b1;
        pen_color = 16'h3C3C;
        @(negedge clk);
        draw_req = 1'b0;
        begin
            int k;
            for (k = 0; k < 50 && !avm_write; k++) @(negedge clk);
            check("midwrite reached write", avm_write, 1);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("midwrite avm_write", avm_write, 0);
        check("midwrite busy", busy, 0);
        check("midwrite avm_address", avm_address, 0);
        check("midwrite avm_writedata", avm_writedata, 0);
        check("midwrite pix_count", pix_count, 0);
        check("midwrite gen_ack", gen_ack, 0);
        rst = 1'b1;
        @(negedge clk);
        load_vec(vecs[0]);
        run_frame(vecs[0].color, 0);
        verify("after_reset", vecs[0].color, 1, 0);

        // Randomised frames against the reference model
        for (int t = 0; t < 20; t++) begin
            int n, x, y, px, py;
            logic [15:0] color;
            clear_logs();
            n = int'($urandom_range(1, 6));
            gn = n;
            gmode = int'($urandom_range(0, 1));
            color = 16'($urandom);
            px = -1;
            py = -1;
            for (int i = 0; i < n; i++) begin
                do begin
                    x = int'($urandom_range(0, 850));
                    y = int'($urandom_range(0, 650));
                end while (x == px && y == py);
                add_pos(i, x, y, int'($urandom_range(0, 3)));
                px = x;
                py = y;
            end
            run_frame(color, 0);
            verify($sformatf("rand%0d", t), color, 1, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
